fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, 32, data/address width.
REQ-002 Parameter PC_RST_VEC, 32'h00000000, first fetch address after reset.
REQ-003 Parameter DEPTH, 4, instruction buffer entries; power of 2, >=2.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_b  in  1  reset, synchronous, active-low.
REQ-006 redirect_valid  in  1  flush and restart fetch at redirect_pc.
REQ-007 redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (treated as 0).
REQ-008 imem_req  out  1  fetch request to instruction memory.
REQ-009 imem_addr  out  XLEN  word-aligned fetch address.
REQ-010 imem_gnt  in  1  request accepted this cycle (handshake = imem_req & imem_gnt).
REQ-011 imem_rvalid  in  1  response data valid; responses in request order, earliest one cycle after grant.
REQ-012 imem_rdata  in  XLEN  instruction word.
REQ-013 inst_valid  out  1  buffer head holds an instruction for decode.
REQ-014 inst_ready  in  1  decode consumes head this cycle.
REQ-015 inst  out  XLEN  head instruction.
REQ-016 inst_pc  out  XLEN  address of head instruction.

Function
REQ-017 fetch_pc register drives imem_addr; +4 on each grant, wraps modulo 2^XLEN.
REQ-018 imem_req = 1 when occupancy + outstanding < DEPTH (credit rule); buffer SHALL never overflow.
REQ-019 imem_addr SHALL stay stable while imem_req=1 without grant, except in a redirect cycle's successor.
REQ-020 outstanding counter (clog2(DEPTH)+1 bits): +1 on grant, -1 on rvalid, both same cycle = unchanged.
REQ-021 Non-discarded rvalid pushes {imem_rdata, resp_pc} into FIFO; resp_pc then +4.
REQ-022 Pushed entry visible on inst_valid the following cycle; no combinational bypass (grant cycle N -> inst_valid no earlier than N+2).
REQ-023 inst_valid = FIFO non-empty; inst/inst_pc from head; pop when inst_valid & inst_ready.
REQ-024 Simultaneous push and pop SHALL both take effect, occupancy unchanged.
REQ-025 inst_ready with inst_valid=0 SHALL have no effect.
REQ-026 Redirect cycle: FIFO emptied, fetch_pc <= redirect_pc, resp_pc <= redirect_pc, pop ignored.
REQ-027 Redirect: discard counter <= outstanding after that cycle's grant/rvalid updates; i.e. grant in redirect cycle counted as discarded, rvalid in redirect cycle dropped.
REQ-028 While discard > 0, each rvalid decrements discard and outstanding, not pushed, resp_pc unchanged.
REQ-029 First request at redirect_pc issued cycle after redirect, subject to credit rule (discarded outstanding consumes credits).
REQ-030 Back-to-back redirects: last one wins; discard recomputed each time per REQ-027.
REQ-031 rvalid with outstanding=0 is a protocol error; ignored, no state change.

Reset
REQ-032 rst_b=0 at a rising edge: fetch_pc=resp_pc=PC_RST_VEC, FIFO empty, outstanding=discard=0.
REQ-033 During reset: imem_req=0, inst_valid=0; imem_addr=PC_RST_VEC.
REQ-034 Reset mid-operation abandons all outstanding; memory responses after reset release SHALL belong to new requests only (memory reset together).
REQ-035 First request issued in first cycle with rst_b=1.

Verification
REQ-036 Reset release, gnt=1 always, rvalid 1 cycle after gnt, inst_ready=1 -> imem_addr 0,4,8,...; inst_pc 0,4,8 in order, first inst_valid 2 cycles after first grant.
REQ-037 inst_ready=0, gnt=1 -> exactly DEPTH (4) grants, imem_req then 0; raising inst_ready restores one request per pop.
REQ-038 2 requests outstanding, redirect_pc=0x100 -> next 2 rvalids not delivered, next inst_pc=0x100, no stale instruction visible.
REQ-039 Redirect same cycle as grant and rvalid -> granted request discarded, rvalid dropped, discard correct, subsequent inst_pc=redirect_pc.
REQ-040 redirect_pc=0x203 -> imem_addr=0x200, inst_pc=0x200; fetch_pc=0xFFFFFFFC -> next addr 0x0.
REQ-041 rst_b=0 with full FIFO and 2 outstanding -> next cycle inst_valid=0, imem_req=0; after release imem_addr=PC_RST_VEC.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch front end. Issues word-aligned requests
//                to instruction memory under a credit rule so that the
//                instruction buffer can never overflow. Returns words in
//                order to decode together with their PC. A redirect flushes
//                the buffer and discards responses still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] PC_RST_VEC = {XLEN{1'b0}},
   parameter int              DEPTH      = 4
) (
   input  logic            clk_i,
   input  logic            rst_b_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] inst_pc_o
);

   // Pointer width and counter width (counters must be able to hold DEPTH).
   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = PW + 1;
   localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);
   localparam logic [PW-1:0]   PTR_ONE = PW'(1);

   // Architectural state
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [XLEN-1:0] data_q [DEPTH];
   logic [XLEN-1:0] pcmem_q [DEPTH];

   // Combinational helpers
   logic [XLEN-1:0] redirect_aligned;
   logic [CW:0]     credit_used;
   logic            credit_ok;
   logic            grant;
   logic            rsp;
   logic            push;
   logic            pop;

   assign redirect_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

   // Buffered entries plus in-flight requests (discarded ones included)
   // must leave room for one more response before a new request goes out.
   assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
   assign credit_ok   = (credit_used < DEPTH_C);

   // Outputs are forced quiet while reset is asserted so nothing stale leaks.
   assign imem_req_o   = rst_b_i & credit_ok;
   assign imem_addr_o  = rst_b_i ? fetch_pc_q : PC_RST_VEC;
   assign inst_valid_o = rst_b_i & (count_q != '0);
   assign inst_o       = data_q[rd_ptr_q];
   assign inst_pc_o    = pcmem_q[rd_ptr_q];

   assign grant = imem_req_o & imem_gnt_i;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp   = imem_rvalid_i & (outst_q != '0);

   // Next-state computation for PCs, credit/discard counters and FIFO control.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      push       = 1'b0;
      pop        = 1'b0;

      // Outstanding tracks every granted request until its response returns,
      // regardless of whether that response will be thrown away.
      case ({grant, rsp})
         2'b10:   outst_d = outst_q + CNT_ONE;
         2'b01:   outst_d = outst_q - CNT_ONE;
         default: outst_d = outst_q;
      endcase

      if (redirect_valid_i) begin
         // Everything still in flight after this cycle belongs to the old
         // path, including a request granted right now. A response arriving
         // in this cycle is simply dropped.
         fetch_pc_d = redirect_aligned;
         resp_pc_d  = redirect_aligned;
         discard_d  = outst_d;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end

         if (rsp) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CNT_ONE;
            end else begin
               push = 1'b1;
            end
         end

         pop = inst_valid_o & inst_ready_i;

         if (push) begin
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            resp_pc_d = resp_pc_q + PC_STEP;
         end

         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end

         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_b_i) begin
         fetch_pc_q <= PC_RST_VEC;
         resp_pc_q  <= PC_RST_VEC;
         outst_q    <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Buffer storage: instruction word and its PC written at the tail.
   always_ff @(posedge clk_i) begin
      if (rst_b_i && push) begin
         data_q[wr_ptr_q]  <= imem_rdata_i;
         pcmem_q[wr_ptr_q] <= resp_pc_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. Directed vector table,
//                hand-written corner sequences and a randomized run against
//                a queue-based reference model with an in-order memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

   localparam logic [31:0] RST_VEC = 32'h0000_0000;
   localparam int          DEPTH   = 4;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   fetch_queue #(.XLEN(32), .PC_RST_VEC(RST_VEC), .DEPTH(DEPTH)) dut (
      .clk_i            (clk),
      .rst_b_i          (rst_b),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .imem_req_o       (imem_req),
      .imem_addr_o      (imem_addr),
      .imem_gnt_i       (imem_gnt),
      .imem_rvalid_i    (imem_rvalid),
      .imem_rdata_i     (imem_rdata),
      .inst_valid_o     (inst_valid),
      .inst_ready_i     (inst_ready),
      .inst_o           (inst),
      .inst_pc_o        (inst_pc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed { logic [31:0] pc; logic stale; }         req_t;
   typedef struct packed { logic [31:0] inst; logic [31:0] pc; }   ent_t;
   typedef struct packed { logic [31:0] data; logic [31:0] due; }  pend_t;

   req_t        m_out[$];   // requests granted, awaiting response
   ent_t        m_fifo[$];  // instructions visible to decode
   pend_t       m_mem[$];   // memory-side pending responses, in order
   logic [31:0] m_fetch = RST_VEC;
   int          cyc = 0;
   int          min_lat = 1;
   int          max_lat = 1;
   int          dut_grants = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   // One clock cycle: drive inputs, compare outputs with the model, advance.
   task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic gnt, input logic ready, input logic spur);
      logic        exp_req, rv, spurious, pop;
      logic [31:0] rd;
      req_t        r;
      pend_t       p;
      rst_b = rst; redirect_valid = redir; redirect_pc = rpc;
      imem_gnt = gnt; inst_ready = ready;
      rv = rst && (m_mem.size() > 0) && (m_mem[0].due <= 32'(cyc));
      rd = rv ? m_mem[0].data : $urandom;
      spurious = 1'b0;
      if (spur && rst && !rv && m_out.size() == 0) begin
         rv = 1'b1;
         spurious = 1'b1;
      end
      imem_rvalid = rv; imem_rdata = rd;
      #1;
      exp_req = rst && (m_fifo.size() + m_out.size() < DEPTH);
      chk("imem_req", imem_req, exp_req);
      chk("imem_addr", imem_addr, rst ? m_fetch : RST_VEC);
      chk("inst_valid", inst_valid, rst && m_fifo.size() > 0);
      if (rst && m_fifo.size() > 0) begin
         chk("inst", inst, m_fifo[0].inst);
         chk("inst_pc", inst_pc, m_fifo[0].pc);
      end
      if (imem_req && gnt) dut_grants++;
      if (!rst) begin
         m_out.delete(); m_fifo.delete(); m_mem.delete();
         m_fetch = RST_VEC;
      end else begin
         pop = ready && m_fifo.size() > 0 && !redir;
         if (pop) void'(m_fifo.pop_front());
         if (rv && !spurious) begin
            void'(m_mem.pop_front());
            r = m_out.pop_front();
            if (!redir && !r.stale) m_fifo.push_back('{inst: rd, pc: r.pc});
         end
         if (exp_req && gnt) begin
            m_out.push_back('{pc: m_fetch, stale: 1'b0});
            p.data = mem_word(m_fetch);
            p.due  = 32'(cyc + $urandom_range(max_lat, min_lat));
            m_mem.push_back(p);
            m_fetch = m_fetch + 32'd4;
         end
         if (redir) begin
            m_fifo.delete();
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_fetch = {rpc[31:2], 2'b00};
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        gnt;
      logic        rv;
      logic [31:0] rd;
      logic        rdy;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evalid;
      logic [31:0] epc;
      logic [31:0] einst;
   } vec_t;

   vec_t vec[9];

   initial begin
      logic seen;
      // Streaming from reset, redirect coinciding with grant and rvalid,
      // misaligned redirect target, stall and pop-on-empty.
      vec[0] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h000, 1'b0, 32'h0,   32'h0};
      vec[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hA000_0000, 1'b1, 1'b1, 32'h004, 1'b0, 32'h0,   32'h0};
      vec[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hA100_0004, 1'b1, 1'b1, 32'h008, 1'b1, 32'h000, 32'hA000_0000};
      vec[3] = '{1'b1, 32'h203, 1'b1, 1'b1, 32'hDEAD_0008, 1'b1, 1'b1, 32'h00C, 1'b1, 32'h004, 32'hA100_0004};
      vec[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hDEAD_000C, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0};
      vec[5] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hB000_0200, 1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0};
      vec[6] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h204, 1'b1, 32'h200, 32'hB000_0200};
      vec[7] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h204, 1'b1, 32'h200, 32'hB000_0200};
      vec[8] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0};

      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 9; i++) begin
         rst_b = 1'b1;
         redirect_valid = vec[i].redir; redirect_pc = vec[i].rpc;
         imem_gnt = vec[i].gnt; imem_rvalid = vec[i].rv; imem_rdata = vec[i].rd;
         inst_ready = vec[i].rdy;
         #1;
         chk($sformatf("vec%0d imem_req", i), imem_req, vec[i].ereq);
         chk($sformatf("vec%0d imem_addr", i), imem_addr, vec[i].eaddr);
         chk($sformatf("vec%0d inst_valid", i), inst_valid, vec[i].evalid);
         if (vec[i].evalid) begin
            chk($sformatf("vec%0d inst_pc", i), inst_pc, vec[i].epc);
            chk($sformatf("vec%0d inst", i), inst, vec[i].einst);
         end
         @(posedge clk); #1;
      end

      // Credit limit: decode stalled, memory always granting.
      min_lat = 1; max_lat = 1;
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      dut_grants = 0;
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("credit_grants", dut_grants, 4);
      chk("credit_req_low", imem_req, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("refill_grants", dut_grants, 5);

      // Redirect with two requests in flight.
      min_lat = 3; max_lat = 3;
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (inst_valid) seen = 1'b1;
         else step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      end
      chk("redir_seen", seen, 1'b1);
      if (seen) chk("redir_first_pc", inst_pc, 32'h100);

      // Address wrap and misaligned redirect, plus spurious response.
      min_lat = 1; max_lat = 2;
      step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk("wrap_addr", imem_addr, 32'h0);
      for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

      // Reset in the middle of traffic with buffered and in-flight entries.
      min_lat = 2; max_lat = 3;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_imem_req", imem_req, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

      // Randomized traffic against the model.
      min_lat = 1; max_lat = 4;
      for (int c = 0; c < 3000; c++) begin
         logic rs, rdr, g, r, sp;
         rs  = ($urandom_range(999, 0) >= 4);
         rdr = ($urandom_range(99, 0) < 5);
         g   = ($urandom_range(99, 0) < 70);
         r   = ($urandom_range(99, 0) < 60);
         sp  = ($urandom_range(99, 0) < 3);
         step(rs, rdr, $urandom, g, r, sp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
